// File: rtl/s_verify.sv
// Read-back checker for s_mem: sweeps all 256 words and verifies S[i] == i.
// The expected value travels alongside each read through a READ_LATENCY-deep address pipeline.
module s_verify #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    input  logic [7:0] rddata,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_addr,
    output logic [7:0] err_data
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, REPORT} state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] drain_q;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [7:0]              adr_pipe [READ_LATENCY];

    logic       mis_q;
    logic [7:0] cap_addr_q;
    logic [7:0] cap_data_q;

    logic       accept;
    logic       drain_end;
    logic       cmp_valid;
    logic [7:0] cmp_exp;
    logic       cmp_miss;

    assign accept    = (state_q == IDLE) && en;
    assign drain_end = (state_q == DRAIN) && (drain_q == DRAIN_LAST);
    assign cmp_valid = vld_pipe[READ_LATENCY-1];
    assign cmp_exp   = adr_pipe[READ_LATENCY-1];
    assign cmp_miss  = cmp_valid && (rddata != cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_d = READ;
            end
            READ: begin
                if (addr == 8'hFF) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = REPORT;
            end
            REPORT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // addr saturates at 255 through DRAIN and REPORT, back to 0 once idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= 8'h00;
            drain_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr    <= 8'h00;
                    drain_q <= 2'd0;
                end
                READ: begin
                    if (addr != 8'hFF) addr <= addr + 8'd1;
                    drain_q <= 2'd0;
                end
                DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                end
                REPORT: begin
                    addr    <= 8'h00;
                    drain_q <= 2'd0;
                end
                default: begin
                    addr    <= 8'h00;
                    drain_q <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) adr_pipe[i] <= 8'h00;
        end else begin
            vld_pipe[0] <= (state_q == READ);
            adr_pipe[0] <= addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
            end
        end
    end

    // Only the first mismatch of a sweep is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q      <= 1'b0;
            cap_addr_q <= 8'h00;
            cap_data_q <= 8'h00;
        end else if (accept) begin
            mis_q      <= 1'b0;
            cap_addr_q <= 8'h00;
            cap_data_q <= 8'h00;
        end else if (cmp_miss && !mis_q) begin
            mis_q      <= 1'b1;
            cap_addr_q <= cmp_exp;
            cap_data_q <= rddata;
        end
    end

    // The final compare lands in the last DRAIN cycle, so fold it in directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass     <= 1'b0;
            err_addr <= 8'h00;
            err_data <= 8'h00;
        end else if (drain_end) begin
            pass <= !(mis_q || cmp_miss);
            if (mis_q) begin
                err_addr <= cap_addr_q;
                err_data <= cap_data_q;
            end else if (cmp_miss) begin
                err_addr <= cmp_exp;
                err_data <= rddata;
            end else begin
                err_addr <= 8'h00;
                err_data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_s_verify.sv
// Directed bench for s_verify: one instance per read latency, each fed by a model RAM
// of matching delay; sweeps are timed from the accept cycle and results checked at done.
module tb_s_verify;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en1, en2;
    logic       rdy1, rdy2, done1, done2, pass1, pass2;
    logic [7:0] addr1, addr2, ea1, ea2, ed1, ed2;
    logic [7:0] q1, q2a, q2;
    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic       c_rdy, c_done, c_pass;
    logic [7:0] c_addr, c_ea, c_ed;

    s_verify #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .addr(addr1), .rddata(q1),
        .done(done1), .pass(pass1), .err_addr(ea1), .err_data(ed1)
    );

    s_verify #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .addr(addr2), .rddata(q2),
        .done(done2), .pass(pass2), .err_addr(ea2), .err_data(ed2)
    );

    always_ff @(posedge clk) begin
        q1  <= mem[addr1];
        q2a <= mem[addr2];
        q2  <= q2a;
    end

    always_comb begin
        c_rdy  = (sel != 0) ? rdy2  : rdy1;
        c_done = (sel != 0) ? done2 : done1;
        c_pass = (sel != 0) ? pass2 : pass1;
        c_addr = (sel != 0) ? addr2 : addr1;
        c_ea   = (sel != 0) ? ea2   : ea1;
        c_ed   = (sel != 0) ? ed2   : ed1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic v);
        if (sel != 0) en2 = v;
        else          en1 = v;
    endtask

    task automatic mem_identity();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    endtask

    // One sweep from an idle DUT; c counts cycles after the accept cycle.
    task automatic do_sweep(input int lat, input logic e_pass, input logic [7:0] e_ea,
                            input logic [7:0] e_ed, input string tag, input bit poke);
        int c;
        bit seen;
        int late_done;
        check({tag, "_rdy_pre"}, 32'(c_rdy), 32'd1);
        set_en(1'b1);
        tick();
        set_en(1'b0);
        c = 1;
        check({tag, "_addr_first"}, 32'(c_addr), 32'h00);
        seen = 1'b0;
        while (c < 400 && !seen) begin
            tick();
            c++;
            if (poke && c == 50) set_en(1'b1);
            if (poke && c == 51) set_en(1'b0);
            if (c == 129) check({tag, "_addr_mid"}, 32'(c_addr), 32'h80);
            if (c == 256) check({tag, "_addr_last"}, 32'(c_addr), 32'hFF);
            if (c == 257) check({tag, "_addr_drain"}, 32'(c_addr), 32'hFF);
            if (c_done) seen = 1'b1;
        end
        check({tag, "_done_at"}, 32'(c), 32'(257 + lat));
        check({tag, "_pass"}, 32'(c_pass), 32'(e_pass));
        check({tag, "_err_addr"}, 32'(c_ea), 32'(e_ea));
        check({tag, "_err_data"}, 32'(c_ed), 32'(e_ed));
        check({tag, "_rdy_at_done"}, 32'(c_rdy), 32'd0);
        tick();
        check({tag, "_done_width"}, 32'(c_done), 32'd0);
        check({tag, "_rdy_after"}, 32'(c_rdy), 32'd1);
        check({tag, "_pass_hold"}, 32'(c_pass), 32'(e_pass));
        if (poke) begin
            late_done = 0;
            repeat (3) begin
                tick();
                if (c_done) late_done++;
            end
            check({tag, "_busy_en_ignored_rdy"}, 32'(c_rdy), 32'd1);
            check({tag, "_busy_en_ignored_done"}, 32'(late_done), 32'd0);
        end
    endtask

    initial begin
        int t;
        int d1, d2, nd;
        int c;
        rst = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        mem_identity();
        repeat (3) tick();
        rst = 1'b0;

        check("rst_rdy1", 32'(rdy1), 32'd1);
        check("rst_addr1", 32'(addr1), 32'h00);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_pass1", 32'(pass1), 32'd0);
        check("rst_err1", {16'h0, ea1, ed1}, 32'h0);
        check("rst_rdy2", 32'(rdy2), 32'd1);
        check("rst_pass2", 32'(pass2), 32'd0);
        tick();

        sel = 0;
        do_sweep(1, 1'b1, 8'h00, 8'h00, "ident_l1", 1'b1);

        mem[8'h37] = 8'hA5;
        mem[8'hC0] = 8'h00;
        do_sweep(1, 1'b0, 8'h37, 8'hA5, "two_err_l1", 1'b0);
        mem_identity();

        sel = 1;
        do_sweep(2, 1'b1, 8'h00, 8'h00, "ident_l2", 1'b0);
        mem[8'hFF] = 8'hFE;
        do_sweep(2, 1'b0, 8'hFF, 8'hFE, "last_err_l2", 1'b0);
        mem_identity();

        // en held high: back-to-back sweeps, en during done must not start one early.
        sel = 0;
        check("held_rdy_pre", 32'(rdy1), 32'd1);
        en1 = 1'b1;
        t = 0; d1 = -1; d2 = -1; nd = 0;
        while (t < 700 && nd < 2) begin
            tick();
            t++;
            if (done1) begin
                nd++;
                if (nd == 1) begin
                    d1 = t;
                    check("held_rdy_at_done", 32'(rdy1), 32'd0);
                end else begin
                    d2 = t;
                end
            end
        end
        en1 = 1'b0;
        check("held_ndone", 32'(nd), 32'd2);
        check("held_first_done", 32'(d1), 32'd258);
        check("held_gap", 32'(d2 - d1), 32'd259);
        check("held_pass", 32'(pass1), 32'd1);
        tick();
        tick();
        check("held_idle_after", 32'(rdy1), 32'd1);

        // Reset in the middle of a sweep.
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        c = 0;
        while (c < 300 && addr1 != 8'h80) begin
            tick();
            c++;
        end
        check("mid_reached_80", 32'(addr1), 32'h80);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rdy", 32'(rdy1), 32'd1);
        check("mid_rst_addr", 32'(addr1), 32'h00);
        check("mid_rst_pass", 32'(pass1), 32'd0);
        check("mid_rst_done", 32'(done1), 32'd0);
        nd = 0;
        repeat (300) begin
            tick();
            if (done1) nd++;
        end
        check("mid_rst_no_done", 32'(nd), 32'd0);
        do_sweep(1, 1'b1, 8'h00, 8'h00, "after_rst_l1", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
